// File: rtl/cw_slave_bridge_pkg.sv
// cw_pkg: shared CW header field positions, burst-length decode and the
// slave bridge state encoding.
package cw_pkg;

  localparam int CW_HDR_VALID    = 0;
  localparam int CW_HDR_READ     = 1;
  localparam int CW_HDR_BURST    = 2;
  localparam int CW_HDR_BCODE_LO = 3;
  localparam int CW_HDR_BCODE_HI = 4;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_GAP,
    ST_RD_WAIT, ST_RD_REQ, ST_RD_ACK, ST_RD_GAP,
    ST_WR_WAIT, ST_WR_REQ, ST_WR_ACK, ST_WR_GAP,
    ST_ERR, ST_DONE, ST_DRAIN
  } cw_state_e;

  // Beats remaining after the first one; fits the 3-bit beat counter (max 8 beats).
  function automatic logic [2:0] cw_beats_m1(input logic [7:0] hdr);
    logic [3:0] beats;
    beats = hdr[CW_HDR_BURST] ? (4'd1 << hdr[CW_HDR_BCODE_HI:CW_HDR_BCODE_LO]) : 4'd1;
    return 3'(beats - 4'd1);
  endfunction

endpackage

// File: rtl/cw_slave_bridge_if.sv
// cw_if: CW pin bus as seen at the target. wdata is master-driven
// (header/address/write data), rdata/data_oe are the slave's pad drive.
interface cw_if;
  logic        req;
  logic        dir;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        data_oe;
  logic        ack;
  logic        err;

  modport master (output req, dir, wdata, input rdata, data_oe, ack, err);
  modport slave  (input req, dir, wdata, output rdata, data_oe, ack, err);
endinterface

// File: rtl/cw_slave_bridge_watchdog.sv
// cw_mem_watchdog: counts cycles of an outstanding memory request and flags a
// timeout on the TIMEOUT_CYCLES-th cycle without a response. Only built when
// CW_SLAVE_TIMEOUT_EN is defined.
module cw_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mem_req,
  input  logic i_mem_done,
  output logic o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign o_timeout = i_mem_req && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count request cycles; any idle cycle or response rearms the counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     cnt_q <= '0;
    else if (!i_mem_req || i_mem_done) cnt_q <= '0;
    else if (!o_timeout)              cnt_q <= cnt_q + CW'(1);
  end
endmodule

// File: rtl/cw_slave_bridge.sv
// cw_slave_bridge: CW pin-bus target. Decodes the header/address words,
// then runs one single-beat memory access per burst beat, acking each on the
// pins with a mandatory idle cycle between acks.
// Optional: define CW_SLAVE_TIMEOUT_EN to add a memory-ack watchdog.
module cw_slave_bridge
  import cw_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cw_if.slave               cw,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata,
  input  logic              i_mem_ack,
  input  logic              i_mem_err
);

  cw_state_e         state_q, state_d;
  logic [7:0]        addr_hi_q;
  logic              rd_q;
  logic [2:0]        beats_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q, rdata_q;
  logic              timeout, mem_done;

  // Request is a pure function of state so it cannot drop mid-access.
  assign o_mem_req   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ) || (state_q == ST_DRAIN);
  assign o_mem_we    = o_mem_req && !rd_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign mem_done    = i_mem_ack || i_mem_err || timeout;

  // Pin pulses are gated by req so an abandoned transaction never acks.
  assign cw.ack     = cw.req && ((state_q == ST_GAP) || (state_q == ST_RD_ACK) || (state_q == ST_WR_ACK));
  assign cw.err     = cw.req && (state_q == ST_ERR);
  assign cw.rdata   = rdata_q;
  assign cw.data_oe = cw.dir && ((state_q == ST_RD_REQ) || (state_q == ST_RD_ACK) || (state_q == ST_RD_GAP));

`ifdef CW_SLAVE_TIMEOUT_EN
  cw_mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_mem_req  (o_mem_req),
    .i_mem_done (i_mem_ack || i_mem_err),
    .o_timeout  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: req dropping abandons the transaction, draining any in-flight access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cw.req && cw.wdata[CW_HDR_VALID]) state_d = ST_ADDR;
      ST_ADDR:    state_d = cw.req ? ST_GAP : ST_IDLE;
      ST_GAP:     if (!cw.req) state_d = ST_IDLE;
                  else         state_d = rd_q ? ST_RD_WAIT : ST_WR_WAIT;
      ST_RD_WAIT: if (!cw.req)     state_d = ST_IDLE;
                  else if (cw.dir) state_d = ST_RD_REQ;
      ST_RD_REQ:  if (!cw.req)                   state_d = mem_done ? ST_IDLE : ST_DRAIN;
                  else if (i_mem_ack)            state_d = ST_RD_ACK;
                  else if (i_mem_err || timeout) state_d = ST_ERR;
      ST_RD_ACK:  state_d = cw.req ? ST_RD_GAP : ST_IDLE;
      ST_RD_GAP:  if (!cw.req)           state_d = ST_IDLE;
                  else if (beats_q == 0) state_d = ST_DONE;
                  else                   state_d = cw.dir ? ST_RD_REQ : ST_RD_WAIT;
      ST_WR_WAIT: state_d = cw.req ? ST_WR_REQ : ST_IDLE;
      ST_WR_REQ:  if (!cw.req)                   state_d = mem_done ? ST_IDLE : ST_DRAIN;
                  else if (i_mem_ack)            state_d = ST_WR_ACK;
                  else if (i_mem_err || timeout) state_d = ST_ERR;
      ST_WR_ACK:  state_d = cw.req ? ST_WR_GAP : ST_IDLE;
      ST_WR_GAP:  if (!cw.req)           state_d = ST_IDLE;
                  else if (beats_q == 0) state_d = ST_DONE;
                  else                   state_d = ST_WR_REQ;
      ST_ERR:     state_d = cw.req ? ST_DONE : ST_IDLE;
      ST_DONE:    if (!cw.req) state_d = ST_IDLE;
      ST_DRAIN:   if (mem_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: header/address capture, per-beat data and address stepping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_hi_q <= '0;
      rd_q      <= 1'b0;
      beats_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (state_d == ST_ADDR) begin
          addr_hi_q <= cw.wdata[15:8];
          rd_q      <= cw.wdata[CW_HDR_READ];
          beats_q   <= cw_beats_m1(cw.wdata[7:0]);
        end
        ST_ADDR:    addr_q  <= ADDR_W'({addr_hi_q, cw.wdata});
        ST_WR_WAIT: wdata_q <= cw.wdata;
        ST_RD_REQ:  if (state_d == ST_RD_ACK) rdata_q <= i_mem_rdata;
        ST_RD_GAP:  if (state_d == ST_RD_REQ || state_d == ST_RD_WAIT) begin
          addr_q  <= addr_q + ADDR_W'(1);
          beats_q <= beats_q - 3'd1;
        end
        // Master presents the next write word the cycle after the ack.
        ST_WR_GAP:  if (state_d == ST_WR_REQ) begin
          addr_q  <= addr_q + ADDR_W'(1);
          beats_q <= beats_q - 3'd1;
          wdata_q <= cw.wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_slave_bridge.sv
// Scoreboard bench for cw_slave_bridge: stimulus pushes expected pin acks and
// memory accesses; a pin monitor and a memory model pop and compare.
module tb_cw_slave_bridge;

  typedef struct { bit rd; logic [15:0] data; } ack_t;
  typedef struct { bit we; logic [23:0] addr; logic [15:0] wdata; logic [15:0] rdata; bit err; } mem_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        o_mem_req, o_mem_we;
  logic [23:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata = '0;
  logic        i_mem_ack = 0, i_mem_err = 0;

  cw_if cw();

  cw_slave_bridge #(.ADDR_W(24), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .cw(cw),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .i_mem_ack(i_mem_ack), .i_mem_err(i_mem_err)
  );

  always #5 clk = ~clk;

  ack_t exp_ack[$];
  mem_t exp_mem[$];
  int   exp_err = 0;
  int   n_cmp = 0, n_fail = 0, n_ack = 0;
  int   mem_lat = 0, mem_wait = 0;
  bit   mem_hang = 0, prev_ack = 0, oe_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ack(input bit rd, input logic [15:0] d);
    ack_t a; a.rd = rd; a.data = d; exp_ack.push_back(a);
  endtask

  task automatic push_mem(input bit we, input logic [23:0] a, input logic [15:0] wd,
                          input logic [15:0] rd, input bit err);
    mem_t m; m.we = we; m.addr = a; m.wdata = wd; m.rdata = rd; m.err = err;
    exp_mem.push_back(m);
  endtask

  // Pin monitor: every ack/err pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) prev_ack = 0;
    else begin
      if (cw.data_oe) oe_seen = 1;
      if (cw.ack) begin
        n_ack++;
        chk("ack_gap", {31'd0, prev_ack}, 0);
        if (exp_ack.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL ack_unexp: got ack expected none");
        end else begin
          ack_t a;
          a = exp_ack.pop_front();
          n_cmp++;
          if (a.rd) begin
            chk("rd_data", {16'd0, cw.rdata}, {16'd0, a.data});
            chk("rd_oe", {31'd0, cw.data_oe}, 1);
          end
        end
      end
      if (cw.err) begin
        n_cmp++;
        if (exp_err == 0) begin
          n_fail++;
          $display("FAIL err_unexp: got err expected none");
        end else exp_err--;
      end
      prev_ack = cw.ack;
    end
  end

  // Memory model: responds mem_lat cycles into a request, checks the access.
  always @(negedge clk) begin
    mem_t m;
    i_mem_ack = 0;
    i_mem_err = 0;
    if (!rst_n || !o_mem_req) mem_wait = 0;
    else if (!mem_hang) begin
      if (mem_wait < mem_lat) mem_wait++;
      else begin
        mem_wait = 0;
        if (exp_mem.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_unexp: got req addr %h expected none", o_mem_addr);
          i_mem_ack = 1;
        end else begin
          m = exp_mem.pop_front();
          chk("mem_we", {31'd0, o_mem_we}, {31'd0, m.we});
          chk("mem_addr", {8'd0, o_mem_addr}, {8'd0, m.addr});
          if (m.we) chk("mem_wdata", {16'd0, o_mem_wdata}, {16'd0, m.wdata});
          i_mem_rdata = m.rdata;
          if (m.err) i_mem_err = 1; else i_mem_ack = 1;
        end
      end
    end
  end

  task automatic wait_ack(input string name);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = cw.ack;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: got no ack expected ack within 100 cycles", name);
    end
  endtask

  task automatic hdr_addr(input logic [15:0] hdr, input logic [15:0] addr);
    @(posedge clk); #1;
    cw.req = 1; cw.dir = 0; cw.wdata = hdr;
    @(posedge clk); #1;
    cw.wdata = addr;
    wait_ack("addr_ack");
  endtask

  task automatic end_txn();
    @(posedge clk); #1;
    cw.req = 0; cw.dir = 0; cw.wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_mem_req", {31'd0, o_mem_req}, 0);
    chk("idle_oe", {31'd0, cw.data_oe}, 0);
  endtask

  task automatic end_check(input string name);
    chk({name, "_ackq"}, exp_ack.size(), 0);
    chk({name, "_memq"}, exp_mem.size(), 0);
    chk({name, "_errq"}, exp_err, 0);
  endtask

  task automatic rd_txn(input logic [15:0] hdr, input logic [15:0] addr, input int n);
    hdr_addr(hdr, addr);
    @(posedge clk); #1;
    cw.dir = 1;
    for (int i = 0; i < n; i++) wait_ack("rd_ack");
    end_txn();
  endtask

  task automatic wr_txn(input logic [15:0] hdr, input logic [15:0] addr,
                        input logic [15:0] d0, input logic [15:0] d1, input int n);
    hdr_addr(hdr, addr);
    @(posedge clk); #1;
    cw.wdata = d0;
    wait_ack("wr_ack0");
    if (n > 1) begin
      @(posedge clk); #1;
      cw.wdata = d1;
      wait_ack("wr_ack1");
    end
    end_txn();
  endtask

  task automatic chk_outputs_zero(input string p);
    chk({p, "_mem_req"}, {31'd0, o_mem_req}, 0);
    chk({p, "_mem_we"}, {31'd0, o_mem_we}, 0);
    chk({p, "_mem_addr"}, {8'd0, o_mem_addr}, 0);
    chk({p, "_mem_wdata"}, {16'd0, o_mem_wdata}, 0);
    chk({p, "_rdata"}, {16'd0, cw.rdata}, 0);
    chk({p, "_oe"}, {31'd0, cw.data_oe}, 0);
    chk({p, "_ack"}, {31'd0, cw.ack}, 0);
    chk({p, "_err"}, {31'd0, cw.err}, 0);
  endtask

  initial begin
    int hi, a0;
    bit seen;
    cw.req = 0; cw.dir = 0; cw.wdata = 0;
    #22;
    chk_outputs_zero("rst");
    @(posedge clk); #3 rst_n = 1;

    // 4-beat read, header 0xff17 / addr 0xe000
    mem_lat = 0;
    push_ack(0, 0);
    push_mem(0, 24'hffe000, 0, 16'h000e, 0); push_ack(1, 16'h000e);
    push_mem(0, 24'hffe001, 0, 16'h0100, 0); push_ack(1, 16'h0100);
    push_mem(0, 24'hffe002, 0, 16'h0000, 0); push_ack(1, 16'h0000);
    push_mem(0, 24'hffe003, 0, 16'h0000, 0); push_ack(1, 16'h0000);
    a0 = n_ack;
    rd_txn(16'hff17, 16'he000, 4);
    chk("rd4_acks", n_ack - a0, 5);
    end_check("rd4");

    // single write 0x123456 <= 0xbeef, oe must stay low
    mem_lat = 2; oe_seen = 0; a0 = n_ack;
    push_ack(0, 0); push_ack(0, 0);
    push_mem(1, 24'h123456, 16'hbeef, 0, 0);
    wr_txn(16'h1201, 16'h3456, 16'hbeef, 0, 1);
    chk("wr1_acks", n_ack - a0, 2);
    chk("wr1_oe", {31'd0, oe_seen}, 0);
    end_check("wr1");

    // 4-beat read crossing 0x00ffff
    mem_lat = 1;
    push_ack(0, 0);
    push_mem(0, 24'h00fffe, 0, 16'h0a01, 0); push_ack(1, 16'h0a01);
    push_mem(0, 24'h00ffff, 0, 16'h0a02, 0); push_ack(1, 16'h0a02);
    push_mem(0, 24'h010000, 0, 16'h0a03, 0); push_ack(1, 16'h0a03);
    push_mem(0, 24'h010001, 0, 16'h0a04, 0); push_ack(1, 16'h0a04);
    rd_txn(16'h0017, 16'hfffe, 4);
    end_check("rdx");

    // 2-beat write wrapping 0xffffff -> 0x000000
    mem_lat = 0;
    push_ack(0, 0); push_ack(0, 0); push_ack(0, 0);
    push_mem(1, 24'hffffff, 16'ha5a5, 0, 0);
    push_mem(1, 24'h000000, 16'h5a5a, 0, 0);
    wr_txn(16'hff0d, 16'hffff, 16'ha5a5, 16'h5a5a, 2);
    end_check("wrwrap");

    // header without the valid bit is ignored
    a0 = n_ack;
    @(posedge clk); #1;
    cw.req = 1; cw.wdata = 16'h0016;
    repeat (6) @(posedge clk);
    #1 cw.req = 0; cw.wdata = 0;
    repeat (2) @(negedge clk);
    chk("inv_acks", n_ack - a0, 0);
    end_check("inv");

    // memory error on beat 2 of a 4-beat read
    mem_lat = 1;
    push_ack(0, 0);
    push_mem(0, 24'h000100, 0, 16'h1234, 0); push_ack(1, 16'h1234);
    push_mem(0, 24'h000101, 0, 0, 1);
    exp_err = 1;
    hdr_addr(16'h0017, 16'h0100);
    @(posedge clk); #1 cw.dir = 1;
    wait_ack("err_beat1");
    for (int i = 0; i < 30 && exp_err != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    end_txn();
    end_check("merr");

    // req falls while memory is busy: access held, result dropped silently
    mem_hang = 1; mem_lat = 0; a0 = n_ack;
    push_ack(0, 0);
    push_mem(0, 24'h000200, 0, 16'hdead, 0);
    hdr_addr(16'h0013, 16'h0200);
    @(posedge clk); #1 cw.dir = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = o_mem_req; end
    chk("abort_req_seen", {31'd0, seen}, 1);
    @(posedge clk); #1 cw.req = 0; cw.dir = 0;
    repeat (3) @(negedge clk);
    chk("drain_hold", {31'd0, o_mem_req}, 1);
    mem_hang = 0;
    repeat (4) @(negedge clk);
    chk("drain_release", {31'd0, o_mem_req}, 0);
    chk("abort_acks", n_ack - a0, 1);
    end_check("abort");

    // asynchronous reset mid-burst
    mem_lat = 1;
    push_ack(0, 0);
    push_mem(0, 24'h000300, 0, 16'h5555, 0); push_ack(1, 16'h5555);
    push_mem(0, 24'h000301, 0, 16'h6666, 0);
    hdr_addr(16'h0017, 16'h0300);
    @(posedge clk); #1 cw.dir = 1;
    wait_ack("rst_beat1");
    @(posedge clk); #3 rst_n = 0;
    #1 chk_outputs_zero("midrst");
    exp_mem.delete(); exp_ack.delete(); exp_err = 0;
    cw.req = 0; cw.dir = 0; cw.wdata = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;

    // clean single read after the reset
    mem_lat = 0;
    push_ack(0, 0);
    push_mem(0, 24'h420007, 0, 16'h7777, 0); push_ack(1, 16'h7777);
    rd_txn(16'h4203, 16'h0007, 1);
    end_check("postrst");

`ifdef CW_SLAVE_TIMEOUT_EN
    // memory never answers: err after 16 request cycles, request released
    mem_hang = 1;
    push_ack(0, 0);
    exp_err = 1;
    hdr_addr(16'h0003, 16'h0010);
    @(posedge clk); #1 cw.dir = 1;
    hi = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (o_mem_req) hi++;
      seen = cw.err;
    end
    chk("to_cycles", hi, 16);
    @(negedge clk);
    chk("to_release", {31'd0, o_mem_req}, 0);
    mem_hang = 0;
    end_txn();
    end_check("timeout");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500us");
    $fatal(1);
  end

endmodule

// File: doc/cw_slave_bridge.md
Name: cw_slave_bridge

Overview:
- Target side of the CW (compressed-wishbone) pin bus.
- Decodes the two-word CW header/address phase driven by the CW master (req, dir, 16-bit data, ack, err).
- Issues single-beat memory requests for each burst beat; returns read data or accepts write data on the CW pins.
- Sits between the CW pin interface (upstream) and a 16-bit word-addressed memory port (downstream, e.g. boot ROM/SRAM model or FPGA-side memory).

Parameters:
- ADDR_W, 24: memory word-address width; header high byte + address word.
- TIMEOUT_CYCLES, 255: memory-ack watchdog limit. Used only with CW_SLAVE_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, same clock as the CW bus clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cw_req  in  1  master request; high for the whole transaction.
- i_cw_dir  in  1  1 = slave drives data (read data phase).
- i_cw_data  in  16  master-driven header/address/write data.
- o_cw_data  out  16  slave read data.
- o_cw_data_oe  out  1  pad output enable for o_cw_data.
- o_cw_ack  out  1  one-cycle acknowledge pulse.
- o_cw_err  out  1  one-cycle error pulse.
- o_mem_req  out  1  memory request; held until i_mem_ack or i_mem_err.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  ADDR_W  word address.
- o_mem_wdata  out  16  write data.
- i_mem_rdata  in  16  read data, valid with i_mem_ack.
- i_mem_ack  in  1  memory done.
- i_mem_err  in  1  memory error, mutually exclusive with i_mem_ack.

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0. Reset is asynchronous and may occur at any state; any outstanding memory request is dropped.
- Header word:
  - [15:8] addr[23:16].
  - [0] command valid; must be 1, otherwise the word is ignored and the block stays in IDLE.
  - [1] 1 = read, 0 = write.
  - [2] burst enable.
  - [4:3] burst code; beats = 1<<code when [2]=1, else 1. Example: 0x17 = read, 4 beats.
  - [7:5] reserved, ignored.
- IDLE: on i_cw_req=1 with header[0]=1, latch the header → ADDR.
- ADDR: next cycle, latch i_cw_data as addr[15:0]. Pulse o_cw_ack for 1 cycle → GAP, then → RD_REQ (read) or WR_WAIT (write).
- RD_REQ:
  - Wait for i_cw_dir=1.
  - Assert o_mem_req (we=0) at the current address.
  - On i_mem_ack: register rdata to o_cw_data with oe=1 and pulse o_cw_ack the following cycle.
- RD_GAP: one idle cycle with ack=0.
  - If beats remain: address+1 → RD_REQ.
  - Otherwise → DONE.
- WR_WAIT: one cycle after the previous ack, sample i_cw_data as the beat's data.
- WR_REQ: o_mem_req with we=1; on i_mem_ack, pulse o_cw_ack → WR_GAP → next beat or DONE.
- Timing rules:
  - Ack is always followed by at least 1 cycle with ack=0.
  - Minimum per-beat latency is mem latency + 2 cycles.
- DONE: wait for i_cw_req=0 → IDLE.
- o_cw_data_oe = 1 only in read data states while i_cw_dir=1. It is 0 within 1 cycle of i_cw_dir falling.
- i_mem_err: pulse o_cw_err (not ack), abort the burst → DONE.
- i_cw_req falls mid-transaction:
  - An outstanding o_mem_req is held until ack/err, and the result is discarded.
  - Then → IDLE, with no ack/err pulse.
- Address wraps modulo 2^ADDR_W; the beat counter is 3 bits wide.
- The simultaneous case (req fall plus mem ack in the same cycle) follows the abort rule.

Optional Feature:
- CW_SLAVE_TIMEOUT_EN defined: a counter runs while o_mem_req=1. If TIMEOUT_CYCLES is reached without ack/err, the block pulses o_cw_err, deasserts o_mem_req and → DONE.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Shared package cw_pkg:
  - header bit-position constants (CW_HDR_VALID=0, CW_HDR_READ=1, CW_HDR_BURST=2, CW_HDR_BCODE=4:3);
  - burst-length decode function;
  - state enum.
- One natural sub-module: cw_mem_watchdog, the timeout counter, instantiated only under the macro.

Test Plan:
- Header 0xff17, addr 0xe000, mem returns 0x000e, 0x0100, 0x0000, 0x0000 → mem reads 0xffe000..0xffe003; o_cw_data carries those values with 4 ack pulses separated by ≥1 low cycle, plus 1 address ack.
- Header 0x1201, addr 0x3456, data 0xbeef → one mem write to 0x123456 with 0xbeef; 2 acks total; oe stays 0.
- Header 0x0017, addr 0xfffe (4-beat read) → addresses 0x00fffe, 0x00ffff, 0x010000, 0x010001.
- i_mem_err on beat 2 of a 4-beat read → one o_cw_err pulse, no further mem requests; IDLE after req drops.
- i_cw_req falls while mem is busy; i_rst_n low mid-burst → no ack/err pulse, clean return to IDLE. On reset, all outputs are 0 immediately.
- With CW_SLAVE_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem never acks → o_cw_err after 16 cycles of o_mem_req, and o_mem_req is released.
